// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch for a Y86-64 style front end.
// The unit pulls one instruction byte per imem handshake. The first byte
// determines the instruction length. It then presents the decoded fields on a
// valid/ready port and waits for the PC-update stage to supply the next PC.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  output logic        imem_req,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_ack,
  input  logic        imem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] pc,
  output logic [63:0] valP,
  output logic [63:0] valC,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic        instr_invalid,
  output logic        imem_error,
  output logic        halted,
  input  logic        pc_load,
  input  logic [63:0] new_pc
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] OUT     = 3'd2;
  localparam logic [2:0] WAIT_PC = 3'd3;
  localparam logic [2:0] HALT    = 3'd4;

  logic [2:0]  state;
  logic [63:0] fetch_pc;   // PC of the instruction being fetched
  logic [3:0]  count;      // bytes of the current instruction already captured
  logic [3:0]  ilen;       // instruction length, known once byte 0 is in

  // Instruction length from the opcode; unknown opcodes are one byte long.
  function automatic logic [3:0] len_of(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
      4'h7, 4'h8:             len_of = 4'd9;
      4'h3, 4'h4, 4'h5:       len_of = 4'd10;
      default:                len_of = 4'd1;
    endcase
  endfunction

  // Formats whose byte 1 carries the register specifier pair.
  function automatic logic has_regs(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
      default:                                  has_regs = 1'b0;
    endcase
  endfunction

  logic [3:0] byte_len;
  logic       last_byte;
  logic [3:0] const_idx;

  // Length is taken straight from the incoming byte while byte 0 is on the bus.
  always_comb begin
    byte_len  = (count == 4'd0) ? len_of(imem_rdata[7:4]) : ilen;
    last_byte = (count == byte_len - 4'd1);
    const_idx = count - (has_regs(icode) ? 4'd2 : 4'd1);
  end

  assign imem_addr = fetch_pc + {60'd0, count};
  assign imem_req  = (state == FETCH);
  assign out_valid = (state == OUT);
  assign halted    = (state == HALT);

  // Fetch sequencer: byte capture, decode, output hold and PC reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      count         <= 4'd0;
      ilen          <= 4'd1;
      pc            <= 64'd0;
      valP          <= 64'd0;
      valC          <= 64'd0;
      icode         <= 4'h0;
      ifun          <= 4'h0;
      rA            <= 4'hF;
      rB            <= 4'hF;
      instr_invalid <= 1'b0;
      imem_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count <= 4'd0;
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            if (imem_err) begin
              // Abort: present whatever has been decoded so far.
              imem_error <= 1'b1;
              pc         <= fetch_pc;
              valP       <= fetch_pc + {60'd0, (count == 4'd0) ? 4'd1 : ilen};
              count      <= 4'd0;
              state      <= OUT;
            end else begin
              if (count == 4'd0) begin
                icode         <= imem_rdata[7:4];
                ifun          <= imem_rdata[3:0];
                instr_invalid <= (imem_rdata[7:4] > 4'hB);
                ilen          <= len_of(imem_rdata[7:4]);
              end else if (count == 4'd1 && has_regs(icode)) begin
                rA <= imem_rdata[7:4];
                rB <= imem_rdata[3:0];
              end else begin
                // Little-endian: constant byte k lands in bits [8k+7:8k].
                valC[{const_idx[2:0], 3'b000} +: 8] <= imem_rdata;
              end
              if (last_byte) begin
                pc    <= fetch_pc;
                valP  <= fetch_pc + {60'd0, byte_len};
                count <= 4'd0;
                state <= OUT;
              end else begin
                count <= count + 4'd1;
              end
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            if (icode == 4'h0 || imem_error || instr_invalid) begin
              state <= HALT;
            end else begin
              state <= WAIT_PC;
            end
          end
        end
        WAIT_PC: begin
          if (pc_load) begin
            // Start from a clean field set so unused fields read as defaults.
            fetch_pc      <= new_pc;
            count         <= 4'd0;
            icode         <= 4'h0;
            ifun          <= 4'h0;
            rA            <= 4'hF;
            rB            <= 4'hF;
            valC          <= 64'd0;
            instr_invalid <= 1'b0;
            imem_error    <= 1'b0;
            state         <= FETCH;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a byte memory with random ack delays,
// plus a reference decoder that works from the instruction-format table.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic [7:0]  imem_rdata;
  logic        imem_ack;
  logic        imem_err;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pc, valP, valC;
  logic [3:0]  icode, ifun, rA, rB;
  logic        instr_invalid, imem_error, halted;
  logic        pc_load;
  logic [63:0] new_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .imem_err(imem_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .valP(valP), .valC(valC),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .instr_invalid(instr_invalid), .imem_error(imem_error), .halted(halted),
    .pc_load(pc_load), .new_pc(new_pc)
  );

  logic [7:0]  mem [0:1023];
  int          max_wait = 0;
  logic        err_en   = 1'b0;
  logic [63:0] err_addr = 64'd0;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    logic [63:0] pc, valc, valp;
    logic [3:0]  icode, ifun, ra, rb;
    logic        inv, err;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem[a[9:0]];
  endfunction

  // Reference decode: bytes below 'limit' are the ones successfully read.
  function automatic exp_t model(input logic [63:0] at, input int err_idx);
    exp_t e;
    int len, off, limit;
    bit regs, cst;
    logic [7:0] b0;
    e.pc = at; e.icode = 4'h0; e.ifun = 4'h0; e.ra = 4'hF; e.rb = 4'hF;
    e.valc = 64'd0; e.inv = 1'b0; e.err = (err_idx >= 0);
    b0 = rd(at);
    len = 1; regs = 0; cst = 0; off = 1;
    if (err_idx != 0) begin
      e.icode = b0[7:4];
      e.ifun  = b0[3:0];
    end
    case (e.icode)
      4'h0, 4'h1, 4'h9:       len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: begin len = 2; regs = 1; end
      4'h7, 4'h8:             begin len = 9; cst = 1; off = 1; end
      4'h3, 4'h4, 4'h5:       begin len = 10; regs = 1; cst = 1; off = 2; end
      default:                begin len = 1; e.inv = 1'b1; end
    endcase
    limit = (err_idx >= 0) ? err_idx : len;
    if (regs && limit > 1) begin
      e.ra = rd(at + 64'd1) >> 4;
      e.rb = rd(at + 64'd1) & 8'h0F;
    end
    if (cst)
      for (int k = 0; k < 8; k++)
        if (off + k < limit)
          e.valc = e.valc | (64'(rd(at + 64'(off + k))) << (8 * k));
    e.valp = at + 64'(len);
    return e;
  endfunction

  // Memory responder: acks after 0..max_wait idle cycles per byte.
  initial begin
    int wait_left;
    imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = 8'h00; wait_left = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || !imem_req) begin
        imem_ack = 1'b0; imem_err = 1'b0;
        wait_left = $urandom_range(0, max_wait);
      end else if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = rd(imem_addr);
        imem_err   = err_en && (imem_addr == err_addr);
        wait_left  = $urandom_range(0, max_wait);
      end else begin
        imem_ack = 1'b0; imem_err = 1'b0;
        wait_left--;
      end
    end
  end

  // Waits for out_valid; lat counts cycles from the first fetch cycle seen.
  task automatic wait_out(output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 300 && !out_valid; i++) begin
      @(negedge clk);
      if (imem_req) seen = 1;
      if (seen) lat++;
    end
    check("out_valid_seen", out_valid, 1);
  endtask

  task automatic check_fields(input exp_t e, input bit chk_valp);
    check("pc", pc, e.pc);
    check("icode", icode, e.icode);
    check("ifun", ifun, e.ifun);
    check("rA", rA, e.ra);
    check("rB", rB, e.rb);
    check("valC", valC, e.valc);
    check("instr_invalid", instr_invalid, e.inv);
    check("imem_error", imem_error, e.err);
    if (chk_valp) check("valP", valP, e.valp);
  endtask

  task automatic handshake(input exp_t e, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_imem_req", imem_req, 0);
      check_fields(e, !e.err);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_out_valid", out_valid, 0);
  endtask

  task automatic load_pc(input logic [63:0] a);
    pc_load = 1'b1; new_pc = a;
    @(negedge clk);
    pc_load = 1'b0; new_pc = 64'd0;
    check("load_addr", imem_addr, a);
    check("load_req", imem_req, 1);
  endtask

  task automatic run_instr(input logic [63:0] at, input int hold);
    exp_t e;
    int lat;
    load_pc(at);
    wait_out(lat);
    e = model(at, -1);
    check_fields(e, 1'b1);
    $display("txn pc=%h icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h inv=%0b err=%0b",
             pc, icode, ifun, rA, rB, valC, valP, instr_invalid, imem_error);
    handshake(e, hold);
  endtask

  task automatic put_irmovq_at0();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
  endtask

  initial begin
    exp_t e;
    int lat;
    logic [63:0] at;
    reset_n = 1'b0; out_ready = 1'b0; pc_load = 1'b0; new_pc = 64'd0;
    put_irmovq_at0();

    // Outputs while held in reset.
    repeat (2) @(negedge clk);
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_imem_req", imem_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_valP", valP, 0);
    check("rst_valC", valC, 0);
    check("rst_icode", icode, 0);
    check("rst_ifun", ifun, 0);
    check("rst_rA", rA, 4'hF);
    check("rst_rB", rB, 4'hF);
    check("rst_flags", {instr_invalid, imem_error, halted}, 0);

    // irmovq $10,%rdx at 0 with zero-wait memory.
    max_wait = 0;
    reset_n = 1'b1;
    wait_out(lat);
    check("latency_10B", lat, 11);
    e = model(RST_PC, -1);
    check_fields(e, 1'b1);
    check("irmovq_valC", valC, 64'd10);
    check("irmovq_valP", valP, 64'd10);
    $display("txn pc=%h icode=%h rB=%h valC=%h valP=%h", pc, icode, rB, valC, valP);

    // Stall in OUT with a stray pc_load that must be ignored.
    pc_load = 1'b1; new_pc = 64'h300;
    handshake(e, 5);
    pc_load = 1'b0; new_pc = 64'd0;
    repeat (3) begin
      @(negedge clk);
      check("waitpc_req", imem_req, 0);
      check("waitpc_valid", out_valid, 0);
    end

    // Random valid, non-halting instructions at random PCs, random ack delays.
    for (int it = 0; it < 10; it++) begin
      at = (it == 0) ? 64'h40 : 64'($urandom_range(16'h40, 16'h3F0));
      mem[at[9:0]] = {4'($urandom_range(1, 11)), 4'($urandom)};
      for (int k = 1; k < 10; k++) mem[(at[9:0] + 10'(k))] = 8'($urandom);
      max_wait = $urandom_range(0, 4);
      run_instr(at, $urandom_range(0, 3));
    end

    // jXX/call-style 9-byte format.
    mem[10'h100] = 8'h80;
    for (int k = 1; k < 9; k++) mem[10'h100 + 10'(k)] = 8'(k * 17);
    run_instr(64'h100, 1);
    check("call_valC", valC, 64'h8877665544332211);
    check("call_valP", valP, 64'h109);

    // Invalid opcode halts and then ignores pc_load.
    mem[10'h200] = 8'hC0;
    run_instr(64'h200, 0);
    check("inv_halted", halted, 1);
    check("inv_req", imem_req, 0);
    pc_load = 1'b1; new_pc = 64'h40;
    @(negedge clk);
    pc_load = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("halt_stays", halted, 1);
      check("halt_no_req", imem_req, 0);
    end

    // Memory fault on byte 3 of irmovq, with zero and random ack delays.
    for (int pass = 0; pass < 2; pass++) begin
      reset_n = 1'b0;
      put_irmovq_at0();
      err_en = 1'b1; err_addr = RST_PC + 64'd3;
      max_wait = (pass == 0) ? 0 : 4;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wait_out(lat);
      e = model(RST_PC, 3);
      check_fields(e, 1'b0);
      $display("txn pc=%h icode=%h rB=%h valC=%h err=%0b", pc, icode, rB, valC, imem_error);
      handshake(e, $urandom_range(0, 2));
      check("err_halted", halted, 1);
    end
    err_en = 1'b0;

    // Asynchronous reset while byte 5 of mrmovq is outstanding.
    reset_n = 1'b0;
    mem[0] = 8'h50; mem[1] = 8'h12;
    for (int k = 2; k < 10; k++) mem[k] = 8'($urandom);
    max_wait = 4;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 200 && !(imem_req && imem_addr == RST_PC + 64'd5); i++) @(negedge clk);
    check("reach_byte5", imem_addr, RST_PC + 64'd5);
    #2 reset_n = 1'b0;
    #1;
    check("async_req", imem_req, 0);
    check("async_addr", imem_addr, RST_PC);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_valid", out_valid, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("refetch_addr", imem_addr, RST_PC);
    check("refetch_req", imem_req, 1);
    wait_out(lat);
    e = model(RST_PC, -1);
    check_fields(e, 1'b1);
    $display("txn pc=%h icode=%h rA=%h rB=%h valC=%h valP=%h", pc, icode, rA, rB, valC, valP);
    handshake(e, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 64'h0, PC value loaded on reset.
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: imem_addr  output  64  byte address of the requested instruction byte.
REQ-005 SHALL have ports: imem_req  output  1  byte read request, held until imem_ack.
REQ-006 SHALL have ports: imem_rdata  input  8  returned byte, valid when imem_ack=1.
REQ-007 SHALL have ports: imem_ack  input  1  completes one byte read.
REQ-008 SHALL have ports: imem_err  input  1  address fault, sampled with imem_ack.
REQ-009 SHALL have ports: out_valid / out_ready  output / input  1 / 1  decoded-instruction handshake.
REQ-010 SHALL have ports: pc, valP, valC  output  64 each  fetched PC, next sequential PC, constant word.
REQ-011 SHALL have ports: icode, ifun, rA, rB  output  4 each  instruction fields.
REQ-012 SHALL have ports: instr_invalid, imem_error, halted  output  1 each  status flags.
REQ-013 SHALL have ports: pc_load  input  1  strobe; new_pc  input  64  next PC from the PC-update stage.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, OUT, WAIT_PC, HALT.
REQ-015 IDLE SHALL move to FETCH on the first clock after reset release, with byte count = 0.
REQ-016 FETCH SHALL drive imem_addr = PC + byte count and keep imem_req high; a byte SHALL be captured only on a cycle with imem_ack=1, after which the count increments.
REQ-017 Byte 0 SHALL give icode = bits[7:4] and ifun = bits[3:0]; instruction length is then fixed by icode as follows.
REQ-018 Length 1: icode 0 (halt), 1 (nop), 9 (ret).
REQ-019 Length 2: icode 2, 6, A, B (byte 1 gives rA = [7:4], rB = [3:0]).
REQ-020 Length 9: icode 7, 8 (valC = bytes 1..8).
REQ-021 Length 10: icode 3, 4, 5 (rA/rB from byte 1, valC = bytes 2..9).
REQ-022 valC SHALL be assembled little-endian (lowest address = bits[7:0]).
REQ-023 icode > 4'hB SHALL set instr_invalid=1 and use length 1.
REQ-024 Fields a format does not use SHALL read rA = rB = 4'hF and valC = 0.
REQ-025 After the last byte the FSM SHALL enter OUT with valP = PC + length (64-bit, wraps modulo 2^64); pc SHALL equal the fetched PC.
REQ-026 imem_ack with imem_err=1 SHALL abort the fetch, set imem_error=1, and enter OUT with the current fields.
REQ-027 In OUT, out_valid=1; all outputs SHALL stay stable until out_ready=1.
REQ-028 On the out handshake: go to HALT if icode=0, imem_error=1, or instr_invalid=1; otherwise go to WAIT_PC.
REQ-029 WAIT_PC SHALL load PC <= new_pc on pc_load=1, clear the flags, and enter FETCH the next cycle.
REQ-030 pc_load SHALL be ignored in every state except WAIT_PC.
REQ-031 HALT SHALL assert halted=1 and imem_req=0, and is left only by reset.
REQ-032 imem_req SHALL be 0 in every state except FETCH.
REQ-033 Latency: an n-byte instruction with zero-wait ack reaches out_valid n+1 cycles after entering FETCH.

Reset
REQ-034 While reset_n=0: PC = RESET_PC, state = IDLE, byte count = 0.
REQ-035 While reset_n=0 all outputs SHALL be 0, except imem_addr = RESET_PC and rA = rB = 4'hF.
REQ-036 Reset asserted mid-fetch or in OUT SHALL discard the partial instruction immediately; no out_valid pulse follows.

Verification
REQ-037 Memory {30 F2 0A 00 00 00 00 00 00 00} at 0, zero-wait ack -> icode=3, rB=2, valC=10, valP=10, out_valid 11 cycles after FETCH.
REQ-038 Hold out_ready=0 for 5 cycles in OUT -> outputs stable, no imem_req; then pc_load with new_pc=0x40 -> next imem_addr=0x40.
REQ-039 Byte 0x80 followed by 8 bytes 0x11..0x88 at PC 0x100 -> icode=8, valC=0x8877665544332211, valP=0x109.
REQ-040 Byte 0xC0 -> instr_invalid=1, valP=PC+1, HALT after handshake, halted=1, pc_load ignored.
REQ-041 imem_err on byte 3 of irmovq -> imem_error=1, HALT; random ack delays 0-4 cycles give identical fields.
REQ-042 reset_n low while byte 5 of mrmovq is pending -> imem_req=0 and PC=RESET_PC asynchronously; after release, refetch starts at RESET_PC.
